// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and widths for the cache port arbiter
// Purpose: FSM state encoding and the word/byte-enable widths of the Cache port.
// Ports: none (package).
package cache_arbiter_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int ENABLE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - requester and Cache word-port bundle for the arbiter
// Purpose: groups the per-requester valid/done handshake and the Cache word port.
// Ports (signals):
//   req_valid/req_address/req_data_in/req_write_enable : requester -> arbiter, requester i in slice i
//   req_done/req_error/req_data_out/grant                : arbiter -> requesters
//   cache_address/cache_data_in/cache_write_enable       : arbiter -> Cache
//   cache_data_out/cache_data_out_ready/cache_busy       : Cache -> arbiter
// Modports: master = requesters plus Cache side, slave = arbiter.
interface cache_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import cache_arbiter_pkg::*;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*WORD_WIDTH-1:0]   req_address;
    logic [NUM_REQ*WORD_WIDTH-1:0]   req_data_in;
    logic [NUM_REQ*ENABLE_WIDTH-1:0] req_write_enable;
    logic [NUM_REQ-1:0]              req_done;
    logic [WORD_WIDTH-1:0]           req_data_out;
    logic [NUM_REQ-1:0]              req_error;
    logic [NUM_REQ-1:0]              grant;

    logic [WORD_WIDTH-1:0]           cache_address;
    logic [WORD_WIDTH-1:0]           cache_data_in;
    logic [ENABLE_WIDTH-1:0]         cache_write_enable;
    logic [WORD_WIDTH-1:0]           cache_data_out;
    logic                            cache_data_out_ready;
    logic                            cache_busy;

    modport master (
        output req_valid, req_address, req_data_in, req_write_enable,
        output cache_data_out, cache_data_out_ready, cache_busy,
        input  req_done, req_data_out, req_error, grant,
        input  cache_address, cache_data_in, cache_write_enable
    );

    modport slave (
        input  req_valid, req_address, req_data_in, req_write_enable,
        input  cache_data_out, cache_data_out_ready, cache_busy,
        output req_done, req_data_out, req_error, grant,
        output cache_address, cache_data_in, cache_write_enable
    );

endinterface

// File: rtl/cache_arbiter_rr_arbiter.sv
// rtl/cache_arbiter_rr_arbiter.sv - one-hot requester pick with round-robin pointer
// Purpose: combinational winner selection; round-robin search from rr_pointer
//          or fixed lowest-index priority. Pointer advances past the owner on update.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester request lines
//   update       : strobe, move pointer to owner_idx+1 (mod NUM_REQ)
//   owner_idx    : index of the requester just served
//   any_valid    : at least one request present
//   pick_idx     : index of the chosen requester
//   pick_onehot  : one-hot of the chosen requester, 0 when none
module rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int FIXED_PRIORITY = 0,
    parameter int PTR_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               update,
    input  logic [PTR_W-1:0]   owner_idx,
    output logic               any_valid,
    output logic [PTR_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    logic [PTR_W-1:0] rr_pointer_q, rr_pointer_d;
    logic [PTR_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        rr_pointer_d = rr_pointer_q;
        if (update) begin
            // Explicit wrap: NUM_REQ need not be a power of two.
            if (owner_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_pointer_d = '0;
            end else begin
                rr_pointer_d = owner_idx + 1'b1;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        pick_idx  = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (FIXED_PRIORITY != 0) begin
                cand = i;
            end else begin
                cand = (int'(rr_pointer_q) + i) % NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!any_valid && req_valid[cand_idx]) begin
                any_valid = 1'b1;
                pick_idx  = cand_idx;
            end
        end
    end

    assign pick_onehot = any_valid ? (NUM_REQ'(1) << pick_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_pointer_q <= '0;
        end else begin
            rr_pointer_q <= rr_pointer_d;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares the Cache word port between NUM_REQ requesters
// Purpose: one cache transaction at a time: IDLE picks a winner, ISSUE holds
//          the latched request stable for one cycle, WAIT completes on
//          busy low (write) or data_out_ready (read) or times out, DONE
//          releases the grant and advances the round-robin pointer.
// Ports:
//   clk  : br_clk_out domain clock
//   rst  : asynchronous active-high reset
//   bus  : cache_arbiter_if.slave (requester handshakes and Cache word port)
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [NUM_REQ-1:0]      error_q, error_d;
    logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
    logic [WORD_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ENABLE_WIDTH-1:0] we_q, we_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    timeout_hit;
    logic                    complete;

    logic                    arb_any;
    logic [PTR_W-1:0]        arb_idx;
    logic [NUM_REQ-1:0]      arb_onehot;
    logic                    arb_update;

    rr_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .FIXED_PRIORITY (FIXED_PRIORITY),
        .PTR_W          (PTR_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (bus.req_valid),
        .update      (arb_update),
        .owner_idx   (owner_q),
        .any_valid   (arb_any),
        .pick_idx    (arb_idx),
        .pick_onehot (arb_onehot)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        done_d     = '0;
        error_d    = '0;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        arb_update = 1'b0;
        complete   = 1'b0;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

        case (state_q)
            IDLE: begin
                // Busy in IDLE means the cache is filling or evicting.
                if (arb_any && !bus.cache_busy) begin
                    grant_d = arb_onehot;
                    owner_d = arb_idx;
                    addr_d  = bus.req_address[WORD_WIDTH*arb_idx +: WORD_WIDTH];
                    wdata_d = bus.req_data_in[WORD_WIDTH*arb_idx +: WORD_WIDTH];
                    we_d    = bus.req_write_enable[ENABLE_WIDTH*arb_idx +: ENABLE_WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (|we_q) begin
                    complete = !bus.cache_busy;
                end else if (bus.cache_data_out_ready) begin
                    complete   = 1'b1;
                    data_out_d = bus.cache_data_out;
                end
                // A genuine completion wins over a timeout in the same cycle.
                if (complete) begin
                    done_d  = grant_q;
                    we_d    = '0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    done_d  = grant_q;
                    error_d = grant_q;
                    we_d    = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d    = '0;
                arb_update = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            done_q     <= '0;
            error_q    <= '0;
            data_out_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            done_q     <= done_d;
            error_q    <= error_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.grant              = grant_q;
    assign bus.req_done           = done_q;
    assign bus.req_error          = error_q;
    assign bus.req_data_out       = data_out_q;
    assign bus.cache_address      = addr_q;
    assign bus.cache_data_in      = wdata_q;
    assign bus.cache_write_enable = we_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    cache_arbiter_if #(.NUM_REQ(2)) bus_rr ();
    cache_arbiter_if #(.NUM_REQ(2)) bus_fp ();

    cache_arbiter #(.NUM_REQ(2), .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(16)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    cache_arbiter #(.NUM_REQ(2), .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(16)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    task automatic idle_inputs();
        bus_rr.req_valid = '0; bus_rr.req_address = '0; bus_rr.req_data_in = '0;
        bus_rr.req_write_enable = '0; bus_rr.cache_data_out = '0;
        bus_rr.cache_data_out_ready = 1'b0; bus_rr.cache_busy = 1'b0;
        bus_fp.req_valid = '0; bus_fp.req_address = '0; bus_fp.req_data_in = '0;
        bus_fp.req_write_enable = '0; bus_fp.cache_data_out = '0;
        bus_fp.cache_data_out_ready = 1'b0; bus_fp.cache_busy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus_rr.grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", bus_rr.grant); else pass_cnt++;
        total_cnt++; if (bus_rr.req_done !== 2'b00) $display("FAIL reset_done: got %b want 00", bus_rr.req_done); else pass_cnt++;
        total_cnt++; if (bus_rr.req_error !== 2'b00) $display("FAIL reset_error: got %b want 00", bus_rr.req_error); else pass_cnt++;
        total_cnt++; if (bus_rr.req_data_out !== 32'h0) $display("FAIL reset_data_out: got %h want 0", bus_rr.req_data_out); else pass_cnt++;
        total_cnt++; if (bus_rr.cache_address !== 32'h0) $display("FAIL reset_address: got %h want 0", bus_rr.cache_address); else pass_cnt++;
        total_cnt++; if (bus_rr.cache_write_enable !== 4'h0) $display("FAIL reset_we: got %h want 0", bus_rr.cache_write_enable); else pass_cnt++;
        total_cnt++; if (bus_fp.grant !== 2'b00) $display("FAIL reset_fp_grant: got %b want 00", bus_fp.grant); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus_rr.grant !== 2'b00) $display("FAIL idle_no_grant: got %b want 00", bus_rr.grant); else pass_cnt++;
    endtask

    task automatic test_single_write();
        int we_cycles = 0;
        int done_at = -1;
        int done_cycles = 0;
        logic [1:0] done_val = '0;
        logic [1:0] err_val = '0;
        bus_rr.req_address      = {32'h0, 32'h0000_0004};
        bus_rr.req_data_in      = {32'h0, 32'h6f64_4120};
        bus_rr.req_write_enable = {4'h0, 4'hF};
        bus_rr.req_valid        = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus_rr.cache_write_enable == 4'hF) we_cycles++;
            if (bus_rr.req_done != 2'b00) done_cycles++;
            if (c == 1) begin
                total_cnt++; if (bus_rr.grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", bus_rr.grant); else pass_cnt++;
                total_cnt++; if (bus_rr.cache_address !== 32'h4) $display("FAIL wr_address: got %h want 00000004", bus_rr.cache_address); else pass_cnt++;
                total_cnt++; if (bus_rr.cache_data_in !== 32'h6f64_4120) $display("FAIL wr_data_in: got %h want 6f644120", bus_rr.cache_data_in); else pass_cnt++;
            end
            if (bus_rr.req_done != 2'b00 && done_at < 0) begin
                done_at  = c;
                done_val = bus_rr.req_done;
                err_val  = bus_rr.req_error;
                bus_rr.req_valid = 2'b00;
            end
        end
        total_cnt++; if (we_cycles != 2) $display("FAIL wr_we_cycles: got %0d want 2", we_cycles); else pass_cnt++;
        total_cnt++; if (done_at != 3) $display("FAIL wr_done_latency: got %0d want 3", done_at); else pass_cnt++;
        total_cnt++; if (done_val !== 2'b01) $display("FAIL wr_done_owner: got %b want 01", done_val); else pass_cnt++;
        total_cnt++; if (err_val !== 2'b00) $display("FAIL wr_no_error: got %b want 00", err_val); else pass_cnt++;
        total_cnt++; if (done_cycles != 1) $display("FAIL wr_done_pulse: got %0d cycles want 1", done_cycles); else pass_cnt++;
        total_cnt++; if (bus_rr.grant !== 2'b00) $display("FAIL wr_grant_released: got %b want 00", bus_rr.grant); else pass_cnt++;
    endtask

    task automatic test_read_back();
        int done_at = -1;
        logic [1:0] done_val = '0;
        logic [31:0] data_val = '0;
        bus_rr.req_address          = {32'h0, 32'h0000_0004};
        bus_rr.req_write_enable     = '0;
        bus_rr.cache_data_out       = 32'hdead_beef;
        bus_rr.cache_data_out_ready = 1'b0;
        bus_rr.req_valid            = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total_cnt++; if (bus_rr.cache_write_enable !== 4'h0) $display("FAIL rd_we_zero: got %h want 0", bus_rr.cache_write_enable); else pass_cnt++;
            end
            if (c == 2) bus_rr.req_address[31:0] = 32'h0000_0099;
            if (c == 3) begin
                total_cnt++; if (bus_rr.cache_address !== 32'h4) $display("FAIL rd_addr_held: got %h want 00000004", bus_rr.cache_address); else pass_cnt++;
            end
            if (bus_rr.req_done != 2'b00 && done_at < 0) begin
                done_at  = c;
                done_val = bus_rr.req_done;
                data_val = bus_rr.req_data_out;
                bus_rr.req_valid = 2'b00;
                bus_rr.cache_data_out_ready = 1'b0;
            end
            if (c == 5) begin
                bus_rr.cache_data_out       = 32'h6f64_4120;
                bus_rr.cache_data_out_ready = 1'b1;
            end
        end
        total_cnt++; if (done_at != 6) $display("FAIL rd_done_latency: got %0d want 6", done_at); else pass_cnt++;
        total_cnt++; if (done_val !== 2'b01) $display("FAIL rd_done_owner: got %b want 01", done_val); else pass_cnt++;
        total_cnt++; if (data_val !== 32'h6f64_4120) $display("FAIL rd_data: got %h want 6f644120", data_val); else pass_cnt++;
    endtask

    task automatic test_busy_timeout();
        logic grant_seen = 1'b0;
        int done_at = -1;
        logic [1:0] done_val = '0;
        logic [1:0] err_val = '0;
        logic [1:0] err_next = 2'b11;
        bus_rr.cache_busy       = 1'b1;
        bus_rr.req_address      = {32'h0, 32'h0000_0008};
        bus_rr.req_write_enable = '0;
        bus_rr.req_valid        = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus_rr.grant != 2'b00) grant_seen = 1'b1;
        end
        total_cnt++; if (grant_seen !== 1'b0) $display("FAIL busy_no_grant: got grant while busy"); else pass_cnt++;
        bus_rr.cache_busy = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_at > 0 && c == done_at + 1) err_next = bus_rr.req_error;
            if (bus_rr.req_done != 2'b00 && done_at < 0) begin
                done_at  = c;
                done_val = bus_rr.req_done;
                err_val  = bus_rr.req_error;
                bus_rr.req_valid = 2'b00;
            end
        end
        total_cnt++; if (done_at != 18) $display("FAIL to_latency: got %0d want 18", done_at); else pass_cnt++;
        total_cnt++; if (done_val !== 2'b01) $display("FAIL to_done: got %b want 01", done_val); else pass_cnt++;
        total_cnt++; if (err_val !== 2'b01) $display("FAIL to_error: got %b want 01", err_val); else pass_cnt++;
        total_cnt++; if (err_next !== 2'b00) $display("FAIL to_error_pulse: got %b want 00", err_next); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        int done_at = -1;
        logic [1:0] done_val = '0;
        bus_rr.cache_busy       = 1'b0;
        bus_rr.req_address      = {32'h0, 32'h0000_000C};
        bus_rr.req_data_in      = {32'h0, 32'h1234_5678};
        bus_rr.req_write_enable = {4'h0, 4'h3};
        bus_rr.req_valid        = 2'b01;
        @(negedge clk);
        bus_rr.cache_busy = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus_rr.grant !== 2'b01) $display("FAIL mid_grant_wait: got %b want 01", bus_rr.grant); else pass_cnt++;
        total_cnt++; if (bus_rr.cache_write_enable !== 4'h3) $display("FAIL mid_we_wait: got %h want 3", bus_rr.cache_write_enable); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (bus_rr.grant !== 2'b00) $display("FAIL mid_rst_grant: got %b want 00", bus_rr.grant); else pass_cnt++;
        total_cnt++; if (bus_rr.cache_write_enable !== 4'h0) $display("FAIL mid_rst_we: got %h want 0", bus_rr.cache_write_enable); else pass_cnt++;
        total_cnt++; if (bus_rr.cache_address !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", bus_rr.cache_address); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bus_rr.cache_busy = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus_rr.req_done != 2'b00 && done_at < 0) begin
                done_at  = c;
                done_val = bus_rr.req_done;
                bus_rr.req_valid = 2'b00;
            end
        end
        total_cnt++; if (done_at != 3) $display("FAIL mid_after_latency: got %0d want 3", done_at); else pass_cnt++;
        total_cnt++; if (done_val !== 2'b01) $display("FAIL mid_after_done: got %b want 01", done_val); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0] got_arr [3];
        int         at_arr [3];
        logic [1:0] exp_arr [3];
        logic       twohot = 1'b0;
        int         cyc = 0;
        exp_arr = '{2'b01, 2'b10, 2'b01};
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        bus_rr.cache_busy       = 1'b0;
        bus_rr.req_address      = {32'h0000_0020, 32'h0000_0010};
        bus_rr.req_data_in      = {32'hbbbb_0001, 32'haaaa_0000};
        bus_rr.req_write_enable = {4'hF, 4'hF};
        bus_rr.req_valid        = 2'b11;
        for (int k = 0; k < 3; k++) begin
            got_arr[k] = 2'b00;
            at_arr[k]  = -1;
            for (int c = 0; c < 10 && got_arr[k] == 2'b00; c++) begin
                @(negedge clk);
                cyc++;
                if ($countones(bus_rr.grant) > 1) twohot = 1'b1;
                if (bus_rr.req_done != 2'b00) begin
                    got_arr[k] = bus_rr.req_done;
                    at_arr[k]  = cyc;
                end
            end
        end
        bus_rr.req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (got_arr[k] !== exp_arr[k]) $display("FAIL rr_order_%0d: got %b want %b", k, got_arr[k], exp_arr[k]); else pass_cnt++;
        end
        total_cnt++; if (at_arr[1] - at_arr[0] != 4) $display("FAIL rr_spacing: got %0d want 4", at_arr[1] - at_arr[0]); else pass_cnt++;
        total_cnt++; if (twohot !== 1'b0) $display("FAIL rr_twohot: grant was two-hot"); else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic [1:0] got_arr [4];
        logic [1:0] exp_arr [4];
        logic       twohot = 1'b0;
        exp_arr = '{2'b01, 2'b01, 2'b01, 2'b10};
        bus_fp.cache_busy       = 1'b0;
        bus_fp.req_address      = {32'h0000_0040, 32'h0000_0030};
        bus_fp.req_write_enable = {4'hF, 4'hF};
        bus_fp.req_valid        = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got_arr[k] = 2'b00;
            for (int c = 0; c < 10 && got_arr[k] == 2'b00; c++) begin
                @(negedge clk);
                if ($countones(bus_fp.grant) > 1) twohot = 1'b1;
                if (bus_fp.req_done != 2'b00) begin
                    got_arr[k] = bus_fp.req_done;
                    if (k == 2) bus_fp.req_valid = 2'b10;
                end
            end
        end
        bus_fp.req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (got_arr[k] !== exp_arr[k]) $display("FAIL fp_order_%0d: got %b want %b", k, got_arr[k], exp_arr[k]); else pass_cnt++;
        end
        total_cnt++; if (twohot !== 1'b0) $display("FAIL fp_twohot: grant was two-hot"); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        repeat (2) @(negedge clk);
        test_read_back();
        repeat (2) @(negedge clk);
        test_busy_timeout();
        repeat (2) @(negedge clk);
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        test_contention();
        test_fixed_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
